// File: rtl/count_sampler_pkg.sv
// Shared constants, level-width helper and the buffered entry layout.
// Optional: COUNT_SAMPLER_WRAP_FLAG_EN adds a wrap bit to each entry.
package count_sampler_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 4;

    // One extra bit so the level can represent a full FIFO.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic [WIDTH_DEF-1:0] data;
`ifdef COUNT_SAMPLER_WRAP_FLAG_EN
        logic                 wrap;
`endif
    } entry_t;

endpackage

// File: rtl/count_sampler_if.sv
// Show-ahead output stream: out_data/out_valid from producer, out_ready back.
// Optional: COUNT_SAMPLER_WRAP_FLAG_EN adds out_wrap alongside out_data.
interface count_sampler_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
`ifdef COUNT_SAMPLER_WRAP_FLAG_EN
    logic             out_wrap;
`endif

    modport master (
        output out_data,
        output out_valid,
`ifdef COUNT_SAMPLER_WRAP_FLAG_EN
        output out_wrap,
`endif
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
`ifdef COUNT_SAMPLER_WRAP_FLAG_EN
        input  out_wrap,
`endif
        output out_ready
    );

endinterface

// File: rtl/count_sampler_fifo.sv
// Show-ahead FIFO of generic entries with level count and sticky overflow.
// Ports: clk, reset, push/push_entry in, pop_ready in, head/head_valid/level/overflow out.
module count_sampler_fifo
    import count_sampler_pkg::*;
#(
    parameter int  DEPTH = DEPTH_DEF,
    parameter type T     = entry_t
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  T                            push_entry,
    input  logic                        pop_ready,
    output T                            head,
    output logic                        head_valid,
    output logic [level_w(DEPTH)-1:0]   level,
    output logic                        overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] cnt;
    logic          ovf;
    logic          full;
    logic          pop;
    logic          do_push;

    assign head_valid = (cnt != '0);
    assign full       = (cnt == LW'(DEPTH));
    assign pop        = head_valid & pop_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push    = push & (~full | pop);

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !pop) begin
                cnt <= cnt + LW'(1);
            end else if (pop && !do_push) begin
                cnt <= cnt - LW'(1);
            end
            if (push && full && !pop) begin
                ovf <= 1'b1;
            end
        end
    end

    always_comb begin
        head = '0;
        if (head_valid) begin
            head = mem[rd_ptr];
        end
    end

    assign level    = cnt;
    assign overflow = ovf;

endmodule

// File: rtl/count_sampler.sv
// Samples an upstream counter into a FIFO whenever its value changes.
// Ports: clk, reset, in_q, level, overflow, out_if (master: out_data/out_valid/out_ready).
// Optional: COUNT_SAMPLER_WRAP_FLAG_EN adds out_wrap, set for samples below their predecessor.
module count_sampler
    import count_sampler_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          in_q,
    count_sampler_if.master           out_if,
    output logic [level_w(DEPTH)-1:0] level,
    output logic                      overflow
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
`ifdef COUNT_SAMPLER_WRAP_FLAG_EN
        logic             wrap;
`endif
    } sample_t;

    logic [WIDTH-1:0] prev_q;
    logic             primed;
    logic             push;
    sample_t          push_entry;
    sample_t          head;
    logic             head_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
            primed <= 1'b0;
        end else begin
            prev_q <= in_q;
            primed <= 1'b1;
        end
    end

    // First cycle after reset always samples; afterwards only on change.
    assign push = ~primed | (in_q != prev_q);

    always_comb begin
        push_entry      = '0;
        push_entry.data = in_q;
`ifdef COUNT_SAMPLER_WRAP_FLAG_EN
        push_entry.wrap = primed & (in_q < prev_q);
`endif
    end

    count_sampler_fifo #(
        .DEPTH (DEPTH),
        .T     (sample_t)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop_ready  (out_if.out_ready),
        .head       (head),
        .head_valid (head_valid),
        .level      (level),
        .overflow   (overflow)
    );

    assign out_if.out_data  = head.data;
    assign out_if.out_valid = head_valid;
`ifdef COUNT_SAMPLER_WRAP_FLAG_EN
    assign out_if.out_wrap  = head.wrap;
`endif

endmodule

// File: doc/count_sampler.md
COUNT_SAMPLER -- requirements
Module: count_sampler

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the width of the sampled count and of out_data.
REQ-002 Parameter DEPTH, default 4 (power of two, at least 2), SHALL set the number of FIFO entries.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be the synchronous, active-high reset.
REQ-005 Port in_q, input, WIDTH bits, SHALL carry the count value produced by the upstream counter.
REQ-006 Port out_data, output, WIDTH bits, SHALL present the oldest buffered sample.
REQ-007 Port out_valid, output, 1 bit, SHALL be high when out_data holds a buffered sample.
REQ-008 Port out_ready, input, 1 bit, SHALL be the consumer's acceptance signal.
REQ-009 Port level, output, $clog2(DEPTH)+1 bits, SHALL give the current number of buffered entries.
REQ-010 Port overflow, output, 1 bit, SHALL be a sticky flag indicating at least one sample was dropped.

Function
REQ-011 Block SHALL hold register prev_q (WIDTH bits) and flag primed; on every non-reset edge, prev_q <= in_q and primed <= 1.
REQ-012 A push request SHALL be raised in a cycle when primed==0, or when in_q != prev_q.
REQ-013 A pop SHALL occur on an edge where out_valid && out_ready are both high.
REQ-014 The FIFO SHALL be show-ahead: a sample pushed at edge N SHALL appear on out_data with out_valid=1 from edge N onward, when the FIFO was empty before that push (one-cycle latency from the in_q change).
REQ-015 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-016 Push onto an empty FIFO SHALL leave level=1; push with no pop SHALL add 1 to level; pop with no push SHALL subtract 1 from level.
REQ-017 Simultaneous push and pop SHALL be allowed at any level from 1 to DEPTH, including full, and SHALL leave level unchanged.
REQ-018 Push when level==DEPTH and no pop SHALL drop the new sample, leave the FIFO contents intact, and set overflow=1.
REQ-019 overflow SHALL stay set until reset.
REQ-020 Read and write pointers SHALL be $clog2(DEPTH) bits wide and SHALL wrap modulo DEPTH.
REQ-021 A pop with level==0 SHALL be impossible, because out_valid=0 when the FIFO is empty.
REQ-022 The change compare SHALL be full-width and unsigned, so a counter wrap from 255 to 0 SHALL count as a change.

Reset
REQ-023 When reset=1 at an edge, the block SHALL set level=0, out_valid=0, overflow=0, pointers=0, prev_q=0, primed=0 and out_data=0.
REQ-024 Reset mid-operation SHALL discard all buffered samples, and the in_q value present in the cycle after reset deasserts SHALL be pushed first.
REQ-025 Reset SHALL take priority over push and pop in the same cycle.

Configuration
REQ-026 With macro COUNT_SAMPLER_WRAP_FLAG_EN defined, the block SHALL add output out_wrap (1 bit) and store one extra bit per entry.
REQ-027 The stored bit SHALL be 1 when a sample is pushed with primed==1 and in_q < prev_q; it SHALL travel with its sample, and out_wrap SHALL reset to 0.
REQ-028 With COUNT_SAMPLER_WRAP_FLAG_EN undefined, the out_wrap port and its storage SHALL not exist, and all other behaviour SHALL be identical.

Structure
REQ-029 Package count_sampler_pkg SHALL hold the default WIDTH and DEPTH constants, the level-width function, and the entry struct (data plus optional wrap bit).
REQ-030 The storage, pointers, level and overflow logic SHALL live in sub-module count_sampler_fifo.
REQ-031 The change detection SHALL stay in the top module count_sampler.

Verification
REQ-032 Reset, then hold in_q=5 with out_ready=0 -> exactly one entry; level=1, out_data=5, out_valid=1, overflow=0.
REQ-033 Drive in_q 10, 11, 12, 13, 14 on consecutive cycles with out_ready=0 (DEPTH=4) -> 10..13 buffered, level=4, 14 dropped, overflow=1; then out_ready=1 -> outputs 10, 11, 12, 13 in order.
REQ-034 FIFO full, out_ready=1 and in_q changing every cycle -> level stays 4, no drop, overflow stays 0.
REQ-035 in_q sequence 254, 255, 0 with out_ready=1 -> three samples output; with COUNT_SAMPLER_WRAP_FLAG_EN defined, out_wrap=1 only on sample 0.
REQ-036 Assert reset for one cycle with level=3 -> next cycle level=0, out_valid=0, overflow=0; the following in_q value is pushed.
REQ-037 Hold in_q=7 for 20 cycles after its first push -> no further pushes; level unchanged.
